intc: RTL and testbench
=======================

Name: intc

Overview:
- External interrupt controller; the initiator side of the exception-entry interface whose receiving end is the CP0 register file.
- Edge-detects hardware interrupt lines and latches them as pending.
- Applies a software-visible Status register (IE, IM) and presents one prioritised interrupt request, with a ready-made Cause word, to the pipeline/CP0.
- Blocks further requests while a handler runs and re-arms on eret.

Parameters:
- NIRQ, 6, number of hardware interrupt lines; legal range 1..6.
- STATUS_ADR, 12, CP0 register address decoded for the Status register.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  synchronous, active-high reset.
- irq  input  NIRQ  raw interrupt lines, already synchronous to clk; rising edge = event.
- w  input  1  CP0 write strobe (mtc0).
- adr  input  5  CP0 register address.
- wd  input  32  CP0 write data.
- rd  output  32  read data; Status when adr==STATUS_ADR, else 0; combinational.
- int_req  output  1  interrupt request to pipeline/CP0.
- ca  output  32  Cause word to load into CP0 when the interrupt is taken.
- irq_id  output  3  index of the line being requested/serviced.
- taken  input  1  pipeline accepted the request this cycle; CP0 loads ca/epc.
- ex_other  input  1  synchronous exception (ov/dz/sys/brk) entered this cycle.
- eret  input  1  return from handler executed this cycle.

Behaviour:
- Reset (rst=1 at posedge):
  - irq_q, pending, IE, IM all 0; state=IDLE.
  - Outputs: int_req=0, ca=0, irq_id=0.
  - Reset mid-request discards everything, including pending bits.
- Edge detect:
  - irq_q <= irq each cycle.
  - pending[i] set when irq[i] & ~irq_q[i].
  - Level held high produces exactly one pending event.
- Status register:
  - Write when w && adr==STATUS_ADR: IE<=wd[0], IM<=wd[10 +: NIRQ].
  - Read: rd = {IM at [10 +: NIRQ], IE at [0], all other bits 0}.
  - Writes with any other adr are ignored.
- Eligibility: elig = pending & IM.
  - Winner = highest set index of elig; fixed priority, line NIRQ-1 highest.
- State IDLE:
  - int_req=0.
  - ex_other=1 -> SERVICE, pending untouched.
  - Else IE && elig!=0 -> REQ, latching winner into irq_id.
- State REQ:
  - int_req=1.
  - ca: bits[6:2]=0 (ExcCode Int), bits[10 +: NIRQ]=elig, all other bits 0.
  - Priority order within REQ:
    - ex_other=1 -> SERVICE; request withdrawn, pending kept.
    - taken=1 -> clear pending[irq_id], go SERVICE.
    - IE=0 or elig==0 (masked/withdrawn by software) -> IDLE, int_req drops next cycle.
    - Else stay; irq_id re-evaluated each cycle so a higher line pre-empts a not-yet-taken lower one.
- State SERVICE:
  - int_req=0.
  - New edges still latch into pending.
  - eret=1 -> IDLE; the next request can assert at the earliest 1 cycle after IDLE.
  - taken in SERVICE is ignored.
- Simultaneous events:
  - New edge on line i in the same cycle taken clears pending[i] -> set wins; pending[i] stays 1.
  - Status write in the same cycle as taken -> taken still honoured; write takes effect for later decisions.
- Latency:
  - Edge on irq -> pending=1 at next posedge.
  - int_req=1 one posedge later (2 cycles total), given IE=1 and the IM bit set.
- Outputs are registered or decoded from state only. No combinational path from irq to int_req.
- Outputs in IDLE/SERVICE: ca=0; irq_id holds its last value.

Test Plan:
- Reset then write Status wd=0x0000_FC01, pulse irq[3] one cycle -> int_req=1 two cycles later, irq_id=3, ca=0x0000_2000; assert taken -> int_req=0, pending[3]=0, state SERVICE; eret -> IDLE, no further request.
- IE=1, IM=all; rise irq[1] and irq[4] same cycle -> irq_id=4, ca=0x0000_4800; after taken and eret -> second request with irq_id=1, ca=0x0000_0800.
- IE=0, rise irq[2] -> no int_req; read adr 12 -> rd=0x0000_0000 (or the IM value written). Then write wd=0x0000_1001 -> int_req next cycle, irq_id=2.
- In REQ for irq[0], assert ex_other -> int_req=0 next cycle, state SERVICE; eret -> request for irq[0] reasserts (pending kept).
- Hold irq[5] high 20 cycles -> exactly one request/service; new edge on irq[5] coincident with taken -> pending[5] remains 1 and reasserts after eret.
- Assert rst while int_req=1 with pending=6'b101010 -> next cycle int_req=0, rd at adr 12 = 0, no request after rst deasserts with irq held steady.

Source files
------------

// File: rtl/intc.sv
// External interrupt controller: edge-latches irq lines, applies Status IE/IM,
// and raises one prioritised request with a Cause word toward CP0.
module intc #(
  parameter int NIRQ       = 6,
  parameter int STATUS_ADR = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic            w,
  input  logic [4:0]      adr,
  input  logic [31:0]     wd,
  output logic [31:0]     rd,
  output logic            int_req,
  output logic [31:0]     ca,
  output logic [2:0]      irq_id,
  input  logic            taken,
  input  logic            ex_other,
  input  logic            eret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NIRQ-1:0] irq_q;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic            ie_q, ie_d;
  logic [NIRQ-1:0] im_q, im_d;
  logic [2:0]      id_q, id_d;
  logic            req_q;

  logic [NIRQ-1:0] elig;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] clr;
  logic [2:0]      win;
  logic            sw_wr;

  assign rise  = irq & ~irq_q;
  assign elig  = pend_q & im_q;
  assign sw_wr = w && (adr == 5'(STATUS_ADR));

  // Later iterations overwrite, so the highest eligible index wins.
  always_comb begin
    win = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (elig[i]) win = 3'(i);
    end
  end

  always_comb begin
    ie_d = ie_q;
    im_d = im_q;
    if (sw_wr) begin
      ie_d = wd[0];
      im_d = wd[10 +: NIRQ];
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (ex_other) begin
          state_d = SERVICE;
        end else if (ie_q && (elig != '0)) begin
          state_d = REQ;
          id_d    = win;
        end
      end
      REQ: begin
        if (ex_other) begin
          state_d = SERVICE;
        end else if (taken) begin
          state_d = SERVICE;
          for (int i = 0; i < NIRQ; i++) begin
            clr[i] = (id_q == 3'(i));
          end
        end else if (!ie_q || (elig == '0)) begin
          state_d = IDLE;
        end else begin
          id_d = win;
        end
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new edge in the same cycle as the clear keeps the line pending.
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      irq_q   <= '0;
      pend_q  <= '0;
      ie_q    <= 1'b0;
      im_q    <= '0;
      id_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq;
      pend_q  <= pend_d;
      ie_q    <= ie_d;
      im_q    <= im_d;
      id_q    <= id_d;
      req_q   <= (state_d == REQ);
    end
  end

  assign int_req = req_q;
  assign irq_id  = id_q;

  always_comb begin
    ca = '0;
    if (state_q == REQ) ca[10 +: NIRQ] = elig;
  end

  always_comb begin
    rd = '0;
    if (adr == 5'(STATUS_ADR)) begin
      rd[0]           = ie_q;
      rd[10 +: NIRQ]  = im_q;
    end
  end

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: scoreboard of expected requests,
// immediate assertions at every comparison.
module tb_intc;

  localparam int NIRQ = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [NIRQ-1:0] irq;
  logic            w;
  logic [4:0]      adr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic            int_req;
  logic [31:0]     ca;
  logic [2:0]      irq_id;
  logic            taken;
  logic            ex_other;
  logic            eret;

  typedef struct {
    logic [2:0]  id;
    logic [31:0] ca;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  intc #(.NIRQ(NIRQ), .STATUS_ADR(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .w        (w),
    .adr      (adr),
    .wd       (wd),
    .rd       (rd),
    .int_req  (int_req),
    .ca       (ca),
    .irq_id   (irq_id),
    .taken    (taken),
    .ex_other (ex_other),
    .eret     (eret)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] id, input logic [31:0] c);
    exp_t e;
    e.id = id;
    e.ca = c;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expected request and compare against the live outputs.
  task automatic pop_chk(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_req"}, {31'd0, int_req}, 32'd1);
      chk({tag, "_id"}, {29'd0, irq_id}, {29'd0, e.id});
      chk({tag, "_ca"}, ca, e.ca);
    end
  endtask

  task automatic wait_req(input string tag, input int budget);
    int n;
    n = 0;
    while (!int_req && n < budget) begin
      tick();
      n++;
    end
    if (!int_req) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else pop_chk(tag);
  endtask

  task automatic wr_status(input logic [31:0] v);
    w   = 1'b1;
    adr = 5'd12;
    wd  = v;
    tick();
    w   = 1'b0;
  endtask

  task automatic serve;
    taken = 1'b1;
    tick();
    taken = 1'b0;
    eret  = 1'b1;
    tick();
    eret  = 1'b0;
  endtask

  initial begin
    int hi;
    rst = 1'b1; irq = '0; w = 1'b0; adr = 5'd12; wd = '0;
    taken = 1'b0; ex_other = 1'b0; eret = 1'b0;
    tick(2);
    chk("rst_req", {31'd0, int_req}, 32'd0);
    chk("rst_ca", ca, 32'd0);
    chk("rst_id", {29'd0, irq_id}, 32'd0);
    chk("rst_rd", rd, 32'd0);
    rst = 1'b0;
    tick();

    // Single line, two-cycle latency
    wr_status(32'h0000_FC01);
    chk("st_rd", rd, 32'h0000_FC01);
    adr = 5'd11; wd = 32'h0; w = 1'b1;
    tick();
    w = 1'b0; adr = 5'd12;
    #1;
    chk("st_other_adr", rd, 32'h0000_FC01);
    adr = 5'd11;
    #1;
    chk("rd_other_adr", rd, 32'h0);
    adr = 5'd12;
    irq = 6'b001000;
    push(3'd3, 32'h0000_2000);
    tick();
    irq = '0;
    chk("lat1_req", {31'd0, int_req}, 32'd0);
    tick();
    pop_chk("t1");
    taken = 1'b1;
    tick();
    taken = 1'b0;
    chk("t1_taken_req", {31'd0, int_req}, 32'd0);
    chk("t1_taken_ca", ca, 32'd0);
    chk("t1_hold_id", {29'd0, irq_id}, 32'd3);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    tick(3);
    chk("t1_no_more", {31'd0, int_req}, 32'd0);

    // Two lines at once: higher index first
    irq = 6'b010010;
    push(3'd4, 32'h0000_4800);
    push(3'd1, 32'h0000_0800);
    tick();
    irq = '0;
    wait_req("t2a", 4);
    serve();
    wait_req("t2b", 4);
    serve();

    // IE=0 masks; enabling later releases the request
    wr_status(32'h0000_FC00);
    irq = 6'b000100;
    tick();
    irq = '0;
    tick(3);
    chk("t3_masked", {31'd0, int_req}, 32'd0);
    chk("t3_rd", rd, 32'h0000_FC00);
    wr_status(32'h0000_1001);
    chk("t3_wr_edge", {31'd0, int_req}, 32'd0);
    push(3'd2, 32'h0000_1000);
    tick();
    pop_chk("t3");
    serve();

    // ex_other withdraws request, pending kept; taken ignored in SERVICE
    wr_status(32'h0000_FC01);
    irq = 6'b000001;
    push(3'd0, 32'h0000_0400);
    tick();
    irq = '0;
    tick();
    pop_chk("t4a");
    ex_other = 1'b1;
    tick();
    ex_other = 1'b0;
    chk("t4_exo_req", {31'd0, int_req}, 32'd0);
    taken = 1'b1;
    tick();
    taken = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    push(3'd0, 32'h0000_0400);
    tick();
    pop_chk("t4b");
    serve();

    // Level held high: one event only
    irq = 6'b100000;
    push(3'd5, 32'h0000_8000);
    tick(2);
    pop_chk("t5a");
    serve();
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (int_req) hi++;
    end
    chk("t5_level_once", hi, 32'd0);
    irq = '0;
    tick();

    // New edge coincident with taken keeps the line pending
    irq = 6'b100000;
    push(3'd5, 32'h0000_8000);
    tick();
    irq = '0;
    tick();
    pop_chk("t5b");
    irq = 6'b100000;
    taken = 1'b1;
    tick();
    taken = 1'b0;
    irq = '0;
    chk("t5_taken_req", {31'd0, int_req}, 32'd0);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    push(3'd5, 32'h0000_8000);
    tick();
    pop_chk("t5c");
    serve();

    // Reset mid-request discards everything
    irq = 6'b101010;
    push(3'd5, 32'h0000_A800);
    tick(2);
    pop_chk("t6");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_req", {31'd0, int_req}, 32'd0);
    chk("t6_rst_rd", rd, 32'd0);
    chk("t6_rst_id", {29'd0, irq_id}, 32'd0);
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (int_req) hi++;
    end
    chk("t6_quiet", hi, 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
